// File: rtl/dma_dsc_scheduler.sv
// dma_dsc_scheduler: per-channel command FIFO, descriptor splitter and credit-limited XDMA bypass issuer; DSC_SPLIT_EN enables MAX_CHUNK boundary splitting
module dma_dsc_scheduler #(
  parameter int NUM_CH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_CHUNK = 4096,
  parameter int MAX_OUTST = 4
) (
  input  logic pcie_clk,
  input  logic pcie_rst,
  input  logic [NUM_CH-1:0] cmd_valid,
  output logic [NUM_CH-1:0] cmd_ready,
  input  logic [NUM_CH-1:0][63:0] cmd_addr,
  input  logic [NUM_CH-1:0][31:0] cmd_len,
  input  logic [NUM_CH-1:0] dsc_byp_ready,
  output logic [NUM_CH-1:0] dsc_byp_load,
  output logic [NUM_CH-1:0][63:0] dsc_byp_addr,
  output logic [NUM_CH-1:0][27:0] dsc_byp_len,
  input  logic [NUM_CH-1:0] dsc_cmp,
  output logic [NUM_CH-1:0] cmd_issued,
  output logic [NUM_CH-1:0][$clog2(MAX_OUTST+1)-1:0] outst_cnt,
  output logic [NUM_CH-1:0] err_cmp
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTST + 1);
  typedef enum logic [1:0] {IDLE, POP, ISSUE} state_t;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [95:0] mem [FIFO_DEPTH];
    logic [95:0] head;
    logic [AW:0] wp, rp;
    logic full, empty, push, pop, fire, last;
    state_t st, nst;
    logic [63:0] cur_addr, addr_q;
    logic [31:0] rem_len, chunk, head_len;
    logic [27:0] len_q;
    logic [OW-1:0] cnt;
    logic load_q, issued_q, err_q;
    assign head = mem[rp[AW-1:0]];
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = wp == rp;
    assign push = cmd_valid[c] && !full;
    assign pop = st == IDLE && !empty;
`ifdef DSC_SPLIT_EN
    logic [31:0] room;
    assign room = 32'(MAX_CHUNK) - (cur_addr[31:0] & 32'(MAX_CHUNK - 1));
    assign chunk = rem_len < room ? rem_len : room;
    assign head_len = head[31:0];
`else
    localparam int unused_chunk = MAX_CHUNK;
    logic unused_hi;
    assign unused_hi = ^head[31:28];
    assign chunk = rem_len;
    assign head_len = {4'd0, head[27:0]};
`endif
    assign last = chunk == rem_len;
    assign fire = st == ISSUE && dsc_byp_ready[c] && cnt < OW'(MAX_OUTST);
    // command storage, written on accepted push
    always_ff @(posedge pcie_clk)
      if (push) mem[wp[AW-1:0]] <= {cmd_addr[c], cmd_len[c]};
    // FIFO pointers with wrap bit to tell full from empty
    always_ff @(posedge pcie_clk or posedge pcie_rst)
      if (pcie_rst) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= wp + (AW+1)'(1);
        if (pop) rp <= rp + (AW+1)'(1);
      end
    // FSM state register
    always_ff @(posedge pcie_clk or posedge pcie_rst)
      if (pcie_rst) st <= IDLE;
      else st <= nst;
    // FSM next state: pop a command, then issue its descriptors
    always_comb begin
      nst = st;
      case (st)
        IDLE:    nst = empty ? IDLE : POP;
        POP:     nst = rem_len == '0 ? IDLE : ISSUE;
        ISSUE:   nst = fire && last ? IDLE : ISSUE;
        default: nst = IDLE;
      endcase
    end
    // command cursor and registered descriptor outputs
    always_ff @(posedge pcie_clk or posedge pcie_rst)
      if (pcie_rst) begin
        cur_addr <= '0;
        rem_len <= '0;
        load_q <= 1'b0;
        issued_q <= 1'b0;
        addr_q <= '0;
        len_q <= '0;
      end else begin
        load_q <= fire;
        issued_q <= (fire && last) || (st == POP && rem_len == '0);
        if (pop) begin
          cur_addr <= head[95:32];
          rem_len <= head_len;
        end
        if (fire) begin
          addr_q <= cur_addr;
          len_q <= chunk[27:0];
          cur_addr <= cur_addr + 64'(chunk);
          rem_len <= rem_len - chunk;
        end
      end
    // outstanding-descriptor credits and sticky underflow flag
    always_ff @(posedge pcie_clk or posedge pcie_rst)
      if (pcie_rst) begin
        cnt <= '0;
        err_q <= 1'b0;
      end else begin
        if (dsc_cmp[c] && cnt == '0) err_q <= 1'b1;
        if (fire && !dsc_cmp[c]) cnt <= cnt + OW'(1);
        else if (dsc_cmp[c] && !fire && cnt != '0) cnt <= cnt - OW'(1);
      end
    assign cmd_ready[c] = !full;
    assign dsc_byp_load[c] = load_q;
    assign dsc_byp_addr[c] = addr_q;
    assign dsc_byp_len[c] = len_q;
    assign cmd_issued[c] = issued_q;
    assign outst_cnt[c] = cnt;
    assign err_cmp[c] = err_q;
  end
endmodule

// File: tb/tb_dma_dsc_scheduler.sv
// tb_dma_dsc_scheduler: directed and randomized checks of dma_dsc_scheduler against a descriptor-list reference model
module tb_dma_dsc_scheduler;
  localparam int NC = 4;
  localparam int FD = 8;
  localparam int MC = 4096;
  localparam int MO = 4;
  localparam int OW = $clog2(MO + 1);
`ifdef DSC_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  typedef struct {
    logic [63:0] a;
    logic [27:0] l;
    logic last;
    logic zero;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NC-1:0] cmd_valid = '0;
  logic [NC-1:0] cmd_ready;
  logic [NC-1:0][63:0] cmd_addr = '0;
  logic [NC-1:0][31:0] cmd_len = '0;
  logic [NC-1:0] dsc_byp_ready = '0;
  logic [NC-1:0] dsc_byp_load;
  logic [NC-1:0][63:0] dsc_byp_addr;
  logic [NC-1:0][27:0] dsc_byp_len;
  logic [NC-1:0] dsc_cmp = '0;
  logic [NC-1:0] cmd_issued;
  logic [NC-1:0][OW-1:0] outst_cnt;
  logic [NC-1:0] err_cmp;
  ev_t exp_q [NC][$];
  int mo [NC];
  logic em [NC];
  int ld_cnt [NC];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  dma_dsc_scheduler #(.NUM_CH(NC), .FIFO_DEPTH(FD), .MAX_CHUNK(MC), .MAX_OUTST(MO)) dut (
    .pcie_clk(clk), .pcie_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .dsc_byp_ready(dsc_byp_ready), .dsc_byp_load(dsc_byp_load), .dsc_byp_addr(dsc_byp_addr),
    .dsc_byp_len(dsc_byp_len), .dsc_cmp(dsc_cmp), .cmd_issued(cmd_issued),
    .outst_cnt(outst_cnt), .err_cmp(err_cmp)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // expected descriptor list of one command, derived from the chunking rule
  task automatic model_cmd(int c, logic [63:0] a, logic [31:0] l);
    ev_t e;
    logic [63:0] rem, room, n;
    rem = SPLIT ? 64'(l) : 64'(l & 32'h0FFF_FFFF);
    if (rem == 0) begin
      e.a = '0; e.l = '0; e.last = 1'b1; e.zero = 1'b1;
      exp_q[c].push_back(e);
      return;
    end
    while (rem != 0) begin
      room = 64'(MC) - (a % 64'(MC));
      n = (SPLIT && room < rem) ? room : rem;
      e.a = a; e.l = n[27:0]; e.last = n == rem; e.zero = 1'b0;
      exp_q[c].push_back(e);
      a += n;
      rem -= n;
    end
  endtask

  task automatic send(int c, logic [63:0] a, logic [31:0] l);
    int w = 0;
    while (!cmd_ready[c] && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("ch%0d_send_wait", c), cmd_ready[c], 1);
    cmd_valid[c] = 1'b1;
    cmd_addr[c] = a;
    cmd_len[c] = l;
    model_cmd(c, a, l);
    @(negedge clk);
    cmd_valid[c] = 1'b0;
  endtask

  task automatic finish_ch(int c);
    int w = 0;
    while ((exp_q[c].size() != 0 || mo[c] != 0) && w < 1000) begin
      dsc_cmp[c] = mo[c] > 0;
      @(negedge clk);
      w++;
    end
    dsc_cmp[c] = 1'b0;
    chk($sformatf("ch%0d_finish", c), 64'(exp_q[c].size() + mo[c]), 0);
  endtask

  // scoreboard: every load/issued event against the expected list, credits and error flag against the model
  always @(posedge clk) begin
    #1;
    if (mon_en)
      for (int c = 0; c < NC; c++) begin
        ev_t e;
        logic ld, is;
        ld = dsc_byp_load[c];
        is = cmd_issued[c];
        if (ld || is) begin
          if (exp_q[c].size() == 0) chk($sformatf("ch%0d_unexpected", c), {ld, is}, 0);
          else begin
            e = exp_q[c].pop_front();
            chk($sformatf("ch%0d_load", c), ld, !e.zero);
            chk($sformatf("ch%0d_issued", c), is, e.last);
            if (ld) begin
              chk($sformatf("ch%0d_addr", c), dsc_byp_addr[c], e.a);
              chk($sformatf("ch%0d_len", c), dsc_byp_len[c], e.l);
            end
          end
        end
        if (ld) ld_cnt[c]++;
        if (dsc_cmp[c] && mo[c] == 0) em[c] = 1'b1;
        if (ld && !dsc_cmp[c]) mo[c]++;
        else if (dsc_cmp[c] && !ld && mo[c] > 0) mo[c]--;
        chk($sformatf("ch%0d_outst", c), outst_cnt[c], mo[c]);
        chk($sformatf("ch%0d_err", c), err_cmp[c], em[c]);
        chk($sformatf("ch%0d_credit", c), mo[c] <= MO, 1);
      end
  end

  initial begin
    int base, n, k, w;
    logic [63:0] a;
    logic [31:0] l;
    for (int c = 0; c < NC; c++) begin
      mo[c] = 0; em[c] = 1'b0; ld_cnt[c] = 0;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", cmd_ready, 4'hF);
    chk("rst_load", dsc_byp_load, 0);
    chk("rst_addr", 64'(|dsc_byp_addr), 0);
    chk("rst_len", 64'(|dsc_byp_len), 0);
    chk("rst_issued", cmd_issued, 0);
    chk("rst_outst", 64'(outst_cnt), 0);
    chk("rst_err", err_cmp, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    dsc_byp_ready = 4'hF;
    send(0, 64'h1000, 32'd4096);
    repeat (2) @(negedge clk);
    chk("lat_early", dsc_byp_load[0], 0);
    @(negedge clk);
    chk("lat_load", dsc_byp_load[0], 1);
    chk("lat_addr", dsc_byp_addr[0], 64'h1000);
    chk("lat_len", dsc_byp_len[0], 28'd4096);
    chk("lat_issued", cmd_issued[0], 1);
    chk("lat_outst", outst_cnt[0], 1);
    dsc_cmp[0] = 1'b1;
    @(negedge clk);
    dsc_cmp[0] = 1'b0;
    chk("cmp_outst", outst_cnt[0], 0);
    base = ld_cnt[0];
    send(0, 64'h0F00, 32'h1200);
    finish_ch(0);
    chk("split_cnt", 64'(ld_cnt[0] - base), SPLIT ? 3 : 1);
    base = ld_cnt[2];
    send(2, 64'h2_0000, 32'h8000);
    n = exp_q[2].size();
    repeat (20) @(negedge clk);
    chk("credit_stall", 64'(ld_cnt[2] - base), (n < MO) ? n : MO);
    chk("credit_outst", outst_cnt[2], (n < MO) ? n : MO);
    dsc_cmp[2] = 1'b1;
    @(negedge clk);
    dsc_cmp[2] = 1'b0;
    repeat (10) @(negedge clk);
    chk("credit_one", 64'(ld_cnt[2] - base), (n < MO + 1) ? n : MO + 1);
    finish_ch(2);
    send(2, 64'hFFFF_FFFF_FFFF_F800, 32'h1000);
    finish_ch(2);
    dsc_byp_ready[1] = 1'b0;
    base = ld_cnt[1];
    k = 0;
    while (k < 20 && cmd_ready[1]) begin
      cmd_valid[1] = 1'b1;
      cmd_addr[1] = 64'h4_0000 + 64'(k * 'h100);
      cmd_len[1] = 32'h80 + 32'(k);
      model_cmd(1, cmd_addr[1], cmd_len[1]);
      @(negedge clk);
      k++;
    end
    chk("fill_cnt", 64'(k), FD + 1);
    chk("full_ready", cmd_ready[1], 0);
    cmd_addr[1] = 64'hDEAD;
    cmd_len[1] = 32'h10;
    repeat (3) @(negedge clk);
    cmd_valid[1] = 1'b0;
    send(0, 64'h5000, 32'h300);
    repeat (10) @(negedge clk);
    chk("ch0_indep", 64'(exp_q[0].size()), 0);
    chk("ch1_stalled", 64'(ld_cnt[1] - base), 0);
    finish_ch(0);
    dsc_byp_ready[1] = 1'b1;
    finish_ch(1);
    chk("ch1_drained", 64'(ld_cnt[1] - base), FD + 1);
    base = ld_cnt[3];
    send(3, 64'h123, 32'h0);
    finish_ch(3);
    chk("zero_noload", 64'(ld_cnt[3] - base), 0);
    dsc_cmp[3] = 1'b1;
    @(negedge clk);
    dsc_cmp[3] = 1'b0;
    chk("err_set", err_cmp[3], 1);
    chk("err_outst", outst_cnt[3], 0);
    @(negedge clk);
    chk("err_sticky", err_cmp[3], 1);
    dsc_byp_ready[1] = 1'b0;
    send(1, 64'h7000, 32'h40);
    send(1, 64'h7100, 32'h40);
    base = ld_cnt[0];
    send(0, 64'h8000, 32'h4000);
    w = 0;
    while (ld_cnt[0] == base && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rst_wait", ld_cnt[0] != base, 1);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_load", dsc_byp_load[0], 0);
    chk("mid_rst_outst", 64'(outst_cnt), 0);
    chk("mid_rst_ready", cmd_ready, 4'hF);
    chk("mid_rst_err", err_cmp, 0);
    for (int c = 0; c < NC; c++) begin
      exp_q[c].delete();
      mo[c] = 0;
      em[c] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    dsc_byp_ready = 4'hF;
    repeat (10) @(negedge clk);
    chk("fifo_flushed", 64'(ld_cnt[1] - base >= 0 ? exp_q[1].size() : 0), 0);
    base = ld_cnt[0];
    send(0, 64'h9000, 32'h200);
    finish_ch(0);
    chk("post_rst_cnt", 64'(ld_cnt[0] - base), 1);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        dsc_byp_ready[c] = $urandom_range(0, 3) != 0;
        dsc_cmp[c] = mo[c] > 0 && $urandom_range(0, 1) == 1;
        if (cmd_ready[c] && $urandom_range(0, 5) == 0) begin
          a = {$urandom, $urandom};
          if ($urandom_range(0, 1) == 1) a[11:0] = '0;
          l = SPLIT ? $urandom_range(0, 3 * MC) : {4'($urandom_range(0, 15)), 28'($urandom_range(0, 100000))};
          if ($urandom_range(0, 7) == 0) l = SPLIT ? 32'h0 : (l & 32'hF000_0000);
          cmd_valid[c] = 1'b1;
          cmd_addr[c] = a;
          cmd_len[c] = l;
          model_cmd(c, a, l);
        end else cmd_valid[c] = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = '0;
    dsc_cmp = '0;
    dsc_byp_ready = 4'hF;
    for (int c = 0; c < NC; c++) finish_ch(c);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
